// File: rtl/axi4s_if.sv
`timescale 1ns/1ps
// AXI4-Stream video interface: pixel data plus SOF on tuser and EOL on tlast.
interface axi4s_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tuser;
  logic                  tlast;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, tuser, tlast, tvalid, input tready);
  modport slave  (input tdata, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/vga_to_axis.sv
`timescale 1ns/1ps
// vga_to_axis: captures a VGA-timed pixel bus into an AXI4-Stream master through a sync FIFO.
// Define VGA2AXIS_GEOM_CHECK_EN to build the line/frame geometry checker behind err_geom_o.
module vga_to_axis #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 1024,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter bit VSYNC_POL  = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] vid_data_i,
  input  logic                  vid_de_i,
  input  logic                  vid_hsync_i,
  input  logic                  vid_vsync_i,
  axi4s_if.master               m_axis,
  input  logic                  clr_i,
  output logic                  overflow_o,
  output logic [15:0]           frame_cnt_o,
  output logic                  err_geom_o
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam int          EW        = DATA_WIDTH + 2;
  localparam logic [AW:0] DEPTH_LVL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);

  typedef enum logic [1:0] {WAIT_VS, ARM, ACTIVE, DROP} state_t;

  state_t                state;
  logic                  vs_act_q, vs_act_d, vs_start;
  logic [DATA_WIDTH-1:0] hold_pix;
  logic                  hold_sof, hold_valid, sof_pend;
  logic [EW-1:0]         mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr, rd_ptr;
  logic                  fifo_full, fifo_empty, push_ok, ovf, capture, eol, pop_mem;
  logic                  out_valid, out_user, out_last;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  unused_ok;

  // A held pixel is always written on the next cycle: mid-line if DE stays high, as EOL if it drops.
  always_comb begin
    vs_start   = vs_act_q && !vs_act_d;
    fifo_empty = (wr_ptr == rd_ptr);
    fifo_full  = ((wr_ptr - rd_ptr) == DEPTH_LVL);
    ovf        = hold_valid && fifo_full;
    push_ok    = hold_valid && !fifo_full;
    eol        = push_ok && !vid_de_i;
    capture    = vid_de_i && !ovf && (state == ARM || state == ACTIVE);
    pop_mem    = !fifo_empty && (!out_valid || m_axis.tready);
  end

  // NOTE: the storage array has no reset; occupancy is defined solely by the pointers.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= {eol, hold_sof, hold_pix};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= WAIT_VS;
      vs_act_q    <= 1'b0;
      vs_act_d    <= 1'b0;
      hold_pix    <= '0;
      hold_sof    <= 1'b0;
      hold_valid  <= 1'b0;
      sof_pend    <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      out_valid   <= 1'b0;
      out_user    <= 1'b0;
      out_last    <= 1'b0;
      out_data    <= '0;
      overflow_o  <= 1'b0;
      frame_cnt_o <= '0;
    end else begin
      vs_act_q   <= (vid_vsync_i == VSYNC_POL);
      vs_act_d   <= vs_act_q;
      hold_valid <= capture;
      if (capture) begin
        hold_pix <= vid_data_i;
        hold_sof <= sof_pend;
      end
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_mem) begin
        {out_last, out_user, out_data} <= mem[rd_ptr[AW-1:0]];
        out_valid <= 1'b1;
        rd_ptr    <= rd_ptr + PTR_ONE;
      end else if (m_axis.tready) begin
        out_valid <= 1'b0;
      end

      case (state)
        WAIT_VS, DROP: if (vs_start) begin
          state    <= ARM;
          sof_pend <= 1'b1;
        end
        ARM: if (capture) begin
          state    <= ACTIVE;
          sof_pend <= 1'b0;
        end
        ACTIVE: begin
          if (capture) sof_pend <= 1'b0;
          if (vs_start) begin
            sof_pend <= 1'b1;
            if (!ovf) frame_cnt_o <= frame_cnt_o + 16'd1;
          end
        end
        default: state <= WAIT_VS;
      endcase
      // A lost pixel truncates the frame; resynchronise on the next vsync.
      if (ovf) state <= DROP;

      overflow_o <= ovf || (overflow_o && !clr_i);
    end
  end

`ifdef VGA2AXIS_GEOM_CHECK_EN
  localparam logic [15:0] H_EXP = 16'(H_ACTIVE);
  localparam logic [15:0] V_EXP = 16'(V_ACTIVE);
  logic [15:0] px_cnt, ln_cnt;
  logic        geom_set, err_q;

  always_comb begin
    geom_set = (eol && (px_cnt != H_EXP)) ||
               (vs_start && state == ACTIVE && (ln_cnt != V_EXP));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      px_cnt <= '0;
      ln_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (vs_start) begin
        px_cnt <= '0;
        ln_cnt <= '0;
      end else if (eol) begin
        px_cnt <= '0;
        ln_cnt <= ln_cnt + 16'd1;
      end else if (capture) begin
        px_cnt <= px_cnt + 16'd1;
      end
      err_q <= geom_set || (err_q && !clr_i);
    end
  end
  assign err_geom_o = err_q;
`else
  assign err_geom_o = 1'b0;
`endif

  assign m_axis.tvalid = out_valid;
  assign m_axis.tuser  = out_user;
  assign m_axis.tlast  = out_last;
  assign m_axis.tdata  = out_data;

  // hsync is informational only; geometry parameters are idle without the checker.
  assign unused_ok = ^{vid_hsync_i, H_ACTIVE, V_ACTIVE};

endmodule
